// File: rtl/lcd_pkg.sv
// Shared types and defaults for the LCD capture block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default frame geometry, framebuffer bank address width,
// capture FSM state encoding and the 2-bit shade constants.
package lcd_pkg;

    localparam int H_PIXELS_DEF = 160;
    localparam int V_LINES_DEF  = 144;
    localparam int FB_ADDR_W    = 15;

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    typedef logic [1:0] shade_t;

    localparam shade_t SHADE_WHITE = 2'd0;
    localparam shade_t SHADE_LIGHT = 2'd1;
    localparam shade_t SHADE_DARK  = 2'd2;
    localparam shade_t SHADE_BLACK = 2'd3;

endpackage

// File: rtl/lcd_capture_if.sv
// Bundle between the LCD pixel source, the capture block and the framebuffer.
// Latency: n/a (wires only).
// Backpressure: none; the framebuffer must accept one write per cycle.
// Ports: pixel_data/pixel_clock/pixel_latch/vsync/clear_flags come from the
// source (master); fb_we/fb_addr/fb_data and status come from capture (slave).
interface lcd_capture_if
    import lcd_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W
);

    shade_t            pixel_data;
    logic              pixel_clock;
    logic              pixel_latch;
    logic              vsync;
    logic              clear_flags;
    logic              fb_we;
    logic [ADDR_W:0]   fb_addr;
    shade_t            fb_data;
    logic              display_bank;
    logic              frame_done;
    logic              overrun;
    logic              underrun;

    modport master (
        output pixel_data, pixel_clock, pixel_latch, vsync, clear_flags,
        input  fb_we, fb_addr, fb_data, display_bank, frame_done, overrun, underrun
    );

    modport slave (
        input  pixel_data, pixel_clock, pixel_latch, vsync, clear_flags,
        output fb_we, fb_addr, fb_data, display_bank, frame_done, overrun, underrun
    );

endinterface

// File: rtl/edge_detect_sync.sv
// Two-flop register of a level strobe with a rising-edge pulse.
// Latency: input high at edge n gives o_rise high between edges n and n+1.
// Backpressure: none.
// Ports: clock, reset (sync, active-high), i_sig level in, o_rise pulse out.
module edge_detect_sync (
    input  logic clock,
    input  logic reset,
    input  logic i_sig,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_sig;
            r_s2 <= r_s1;
        end
    end

    assign o_rise = r_s1 & ~r_s2;

endmodule

// File: rtl/lcd_capture.sv
// Turns the serial LCD pixel stream into writes on a double-buffered framebuffer.
// Latency: strobe sampled at edge n -> fb_we/fb_addr/fb_data valid after edge n+1.
// Backpressure: none; every accepted pixel is written in a single cycle.
// Ports: clock, reset (sync, active-high), bus (lcd_capture_if.slave).
module lcd_capture
    import lcd_pkg::*;
#(
    parameter int H_PIXELS = H_PIXELS_DEF,
    parameter int V_LINES  = V_LINES_DEF,
    parameter int ADDR_W   = FB_ADDR_W
) (
    input  logic         clock,
    input  logic         reset,
    lcd_capture_if.slave bus
);

    localparam logic [7:0]        H_LIM  = 8'(H_PIXELS);
    localparam logic [7:0]        V_LIM  = 8'(V_LINES);
    localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_PIXELS);

    logic w_pix_rise;
    logic w_latch_rise;
    logic w_vs_rise;

    // Pixel shade only needs the first stage: the write is launched from the
    // edge-detect cycle, where s1 holds the shade captured with the strobe.
    shade_t r_data_s1;

    state_t            r_state,  w_state_n;
    logic [7:0]        r_x,      w_x_n;
    logic [7:0]        r_y,      w_y_n;
    logic [ADDR_W-1:0] r_line_base, w_lb_n;
    logic              r_display_bank, w_bank_n;
    logic              r_fb_we,  w_we_n;
    logic [ADDR_W:0]   r_fb_addr, w_addr_n;
    shade_t            r_fb_data, w_data_n;
    logic              r_frame_done, w_done_n;
    logic              r_overrun,  w_ovr_n;
    logic              r_underrun, w_und_n;
    logic [7:0]        w_x_cur;
    logic [7:0]        w_y_cnt;

    edge_detect_sync u_pix_edge   (.clock(clock), .reset(reset), .i_sig(bus.pixel_clock), .o_rise(w_pix_rise));
    edge_detect_sync u_latch_edge (.clock(clock), .reset(reset), .i_sig(bus.pixel_latch), .o_rise(w_latch_rise));
    edge_detect_sync u_vs_edge    (.clock(clock), .reset(reset), .i_sig(bus.vsync),       .o_rise(w_vs_rise));

    always_comb begin
        w_state_n = r_state;
        w_x_n     = r_x;
        w_y_n     = r_y;
        w_lb_n    = r_line_base;
        w_bank_n  = r_display_bank;
        w_we_n    = 1'b0;
        w_addr_n  = r_fb_addr;
        w_data_n  = r_fb_data;
        w_done_n  = 1'b0;
        // Clear first, then any new error ORs back in, so a set wins.
        w_ovr_n   = r_overrun  & ~bus.clear_flags;
        w_und_n   = r_underrun & ~bus.clear_flags;
        w_x_cur   = r_x;
        w_y_cnt   = r_y;

        case (r_state)
            SYNC: begin
                // Hold off until a frame boundary so no partial frame is captured.
                if (w_vs_rise) begin
                    w_state_n = ACTIVE;
                    w_x_n     = '0;
                    w_y_n     = '0;
                    w_lb_n    = '0;
                end
            end
            ACTIVE: begin
                // A pixel landing with a latch or vsync belongs to the current line.
                if (w_pix_rise) begin
                    if (r_x < H_LIM && r_y < V_LIM) begin
                        w_we_n   = 1'b1;
                        w_addr_n = {~r_display_bank, r_line_base + ADDR_W'(r_x)};
                        w_data_n = r_data_s1;
                        w_x_cur  = r_x + 8'd1;
                    end else begin
                        w_ovr_n = 1'b1;
                    end
                end
                w_x_n = w_x_cur;

                if (w_vs_rise) begin
                    // A coincident latch still closes its line before the short-frame test.
                    w_y_cnt = (w_latch_rise && r_y < V_LIM) ? r_y + 8'd1 : r_y;
                    if (w_y_cnt < V_LIM) begin
                        w_und_n = 1'b1;
                    end
                    w_bank_n = ~r_display_bank;
                    w_done_n = 1'b1;
                    w_x_n    = '0;
                    w_y_n    = '0;
                    w_lb_n   = '0;
                end else if (w_latch_rise) begin
                    if (w_x_cur < H_LIM) begin
                        w_und_n = 1'b1;
                    end
                    w_x_n = '0;
                    if (r_y < V_LIM) begin
                        w_y_n  = r_y + 8'd1;
                        w_lb_n = r_line_base + H_STEP;
                    end else begin
                        w_ovr_n = 1'b1;
                    end
                end
            end
            default: w_state_n = SYNC;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_data_s1      <= '0;
            r_state        <= SYNC;
            r_x            <= '0;
            r_y            <= '0;
            r_line_base    <= '0;
            r_display_bank <= 1'b0;
            r_fb_we        <= 1'b0;
            r_fb_addr      <= '0;
            r_fb_data      <= '0;
            r_frame_done   <= 1'b0;
            r_overrun      <= 1'b0;
            r_underrun     <= 1'b0;
        end else begin
            r_data_s1      <= bus.pixel_data;
            r_state        <= w_state_n;
            r_x            <= w_x_n;
            r_y            <= w_y_n;
            r_line_base    <= w_lb_n;
            r_display_bank <= w_bank_n;
            r_fb_we        <= w_we_n;
            r_fb_addr      <= w_addr_n;
            r_fb_data      <= w_data_n;
            r_frame_done   <= w_done_n;
            r_overrun      <= w_ovr_n;
            r_underrun     <= w_und_n;
        end
    end

    assign bus.fb_we        = r_fb_we;
    assign bus.fb_addr      = r_fb_addr;
    assign bus.fb_data      = r_fb_data;
    assign bus.display_bank = r_display_bank;
    assign bus.frame_done   = r_frame_done;
    assign bus.overrun      = r_overrun;
    assign bus.underrun     = r_underrun;

endmodule

// File: doc/lcd_capture.md
Name: lcd_capture

Overview:
- Sits directly downstream of the gameboy core's LCD pixel outputs: pixel_data, pixel_clock, pixel_latch and vsync.
- Converts the serial 2-bit pixel stream into write transactions on a double-buffered 160x144 framebuffer.
- The future HDMI/DVI scan-out block reads the bank given by display_bank, so the display never shows a frame while it is being written.
- Runs entirely in the core clock domain.

Parameters:
H_PIXELS, 160, pixels accepted per line
V_LINES, 144, lines accepted per frame
ADDR_W, 15, per-bank address width; must satisfy 2^ADDR_W >= H_PIXELS*V_LINES

Ports:
clock  input  1  core clock (33.33 MHz)
reset  input  1  synchronous, active-high reset
pixel_data  input  2  pixel shade, valid at the pixel_clock rising edge
pixel_clock  input  1  pixel strobe from the LCD controller (level signal; rising edge = one pixel)
pixel_latch  input  1  rising edge = end of line
vsync  input  1  rising edge = end of frame
clear_flags  input  1  one-cycle pulse; clears overrun and underrun
fb_we  output  1  framebuffer write enable, one cycle per pixel
fb_addr  output  ADDR_W+1  {write_bank, y*H_PIXELS+x}
fb_data  output  2  pixel written
display_bank  output  1  bank holding the last complete frame
frame_done  output  1  one-cycle pulse after a completed frame swap
overrun  output  1  sticky: pixel beyond H_PIXELS or line beyond V_LINES was dropped
underrun  output  1  sticky: a line or frame ended short

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are named clock and reset.
- Input stage:
  - pixel_clock, pixel_latch, vsync and pixel_data are registered once (s1), then again (s2).
  - Edge detect is s1 & ~s2 for each strobe.
  - fb_we/fb_addr/fb_data are registered from the edge-detect stage. Latency: input rising edge sampled at cycle n -> fb_we high at cycle n+2, fb_data = pixel_data sampled at cycle n.
- Address generation: no multiplier.
  - line_base accumulates +H_PIXELS per line.
  - fb_addr[ADDR_W-1:0] = line_base + x.
  - fb_addr[ADDR_W] = write_bank = ~display_bank.
- FSM states: SYNC, ACTIVE.
  - SYNC (after reset): all strobes ignored until the first vsync edge, then -> ACTIVE with x=0, y=0, line_base=0. Prevents capturing a partial frame.
  - ACTIVE, pixel edge: if x<H_PIXELS and y<V_LINES, write and x++. Otherwise no write and overrun<=1.
  - ACTIVE, latch edge: if x<H_PIXELS, underrun<=1. Then x<=0. If y<V_LINES: y++ and line_base += H_PIXELS. Else overrun<=1 (y saturates at V_LINES).
  - ACTIVE, vsync edge: if y<V_LINES, underrun<=1. Then display_bank<=~display_bank, frame_done pulses 1 cycle later, x=y=line_base=0. Stays ACTIVE.
- Simultaneous events:
  - pixel+latch same cycle: pixel is written to the current line first, then the line advances.
  - latch+vsync same cycle: latch is ignored; vsync handling applies (the line is counted before the underrun check).
  - pixel+vsync same cycle: pixel is written (if in range) before the frame reset.
- Flags:
  - clear_flags clears overrun/underrun.
  - If clear_flags and a new error occur in the same cycle, the flag is set (set wins).
- Reset values:
  - fb_we=0, fb_addr=0, fb_data=0, display_bank=0, frame_done=0, overrun=0, underrun=0.
  - State SYNC; s1/s2 registers=0.
  - Reset mid-frame discards the partial frame with no frame_done.
- Widths: x is 8 bits, y is 8 bits, line_base is ADDR_W bits; none wraps within legal ranges.

Decomposition:
- Shared package lcd_pkg: H_PIXELS/V_LINES defaults, FB_ADDR_W, state encodings (SYNC=1'b0, ACTIVE=1'b1), shade constants.
- One natural sub-module, edge_detect_sync (two-flop register plus rising-edge pulse), instantiated three times.
- Address and FSM logic stay in lcd_capture.

Test Plan:
- Reset, then 160 pixels plus a latch before any vsync -> no fb_we, state stays SYNC, flags 0.
- vsync, then line of 160 pixels data=i%4, then latch -> fb_we pulses 160 times, fb_addr 16'h8000..16'h809F (bank 1), fb_data matches; second line starts at 16'h80A0.
- Full 144x160 frame, then vsync -> 23040 writes, last fb_addr=16'hD9FF, display_bank 0->1, frame_done single pulse, flags 0.
- 161 pixels on a line, then a latch after only 100 pixels -> overrun=1 (pixel 161 not written); underrun=1; clear_flags -> both 0.
- pixel_clock and pixel_latch rise same cycle at x=159 -> pixel written at x=159, next write at x=0 of y+1, underrun stays 0.
- Reset asserted at line 70 -> outputs zeroed the next cycle, no frame_done, writes resume only after the next vsync at bank-1 address 0.
